mem_access_unit: RTL

- Sits between the pipeline MEM stage and the 32-bit stalling data memory.
- Converts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory transactions.
- Waits out memory stalls, performs read-modify-write for sub-word stores, and extracts and extends sub-word load data.
- Flags misaligned, unsupported-size, memory-error and timeout conditions to the pipeline.

---
 rtl/mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: bridges MEM-stage loads/stores to a 32-bit stalling
// word memory, with RMW for sub-word stores, load extension and error flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_wr              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load result (0 for stores / errors)
//   resp_err            error flag, qualified by resp_valid
//   mem_addr            word-aligned memory address
//   mem_data_in         write data to memory
//   mem_enable, mem_wr  memory access / write strobes
//   mem_data_out        read data from memory
//   mem_ready, mem_err  memory completion and error (err qualified by ready)

module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] LP_TMO_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t r_state;
  state_t w_next;

  logic             r_wr;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [15:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdbuf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic        w_req_mis;
  logic        w_tmo;
  logic        w_accept;
  logic        w_ld_rdbuf;
  logic        w_set_err;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_ready;
  logic        w_en;
  logic        w_wr;
  logic        w_resp;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  // Alignment is judged on the fields being latched this cycle, so the
  // decision is already registered when the request lands in RESP.
  assign w_req_mis =
    (req_size == 2'b11) ||
    ((req_size == 2'b01) && req_addr[0]) ||
    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Abort on the stall cycle that brings the count up to TIMEOUT.
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == LP_TMO_LAST);

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ld_rdbuf = 1'b0;
    w_set_err  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_ready    = 1'b0;
    w_en       = 1'b0;
    w_wr       = 1'b0;
    w_resp     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (req_valid) begin
          w_accept  = 1'b1;
          w_cnt_clr = 1'b1;
          if (w_req_mis) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end else if (!req_wr) begin
            w_next = S_RD;
          end else if (req_size == 2'b10) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD: begin
        w_en = 1'b1;
        if (mem_ready) begin
          if (mem_err) begin
            w_set_err = 1'b1;
            w_next    = S_RESP;
          end else begin
            w_ld_rdbuf = 1'b1;
            if (r_wr) begin
              w_cnt_clr = 1'b1;
              w_next    = S_WR;
            end else begin
              w_next = S_RESP;
            end
          end
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WR: begin
        w_en = 1'b1;
        w_wr = 1'b1;
        if (mem_ready) begin
          w_set_err = mem_err;
          w_next    = S_RESP;
        end else if (w_tmo) begin
          w_set_err = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        w_resp = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 32'h0000_0000;
      r_rdbuf <= 32'h0000_0000;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdbuf <= 32'h0000_0000;
        r_err   <= 1'b0;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_ld_rdbuf) begin
        r_rdbuf <= mem_data_out;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_byte = r_rdbuf[7:0];
    unique case (r_addr[1:0])
      2'b00: w_byte = r_rdbuf[7:0];
      2'b01: w_byte = r_rdbuf[15:8];
      2'b10: w_byte = r_rdbuf[23:16];
      2'b11: w_byte = r_rdbuf[31:24];
      default: w_byte = r_rdbuf[7:0];
    endcase
  end

  assign w_half = r_addr[1] ? r_rdbuf[31:16] : r_rdbuf[15:0];

  always_comb begin
    w_ext = r_rdbuf;
    unique case (r_size)
      2'b00: begin
        w_ext = r_uns ? {24'h000000, w_byte}
                      : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_ext = r_uns ? {16'h0000, w_half}
                      : {{16{w_half[15]}}, w_half};
      end
      default: begin
        w_ext = r_rdbuf;
      end
    endcase
  end

  // Store data: full word, or the read-back word with the target lane(s)
  // overwritten.
  always_comb begin
    w_merge = r_rdbuf;
    unique case (r_size)
      2'b00: begin
        unique case (r_addr[1:0])
          2'b00: w_merge[7:0]   = r_wdata[7:0];
          2'b01: w_merge[15:8]  = r_wdata[7:0];
          2'b10: w_merge[23:16] = r_wdata[7:0];
          2'b11: w_merge[31:24] = r_wdata[7:0];
          default: w_merge = r_rdbuf;
        endcase
      end
      2'b01: begin
        if (r_addr[1]) begin
          w_merge[31:16] = r_wdata[15:0];
        end else begin
          w_merge[15:0] = r_wdata[15:0];
        end
      end
      default: begin
        w_merge = r_wdata;
      end
    endcase
  end

  // Reset gates every output combinationally so the memory sees
  // nothing while it loads.
  assign req_ready   = w_ready & ~rst;
  assign mem_enable  = w_en & ~rst;
  assign mem_wr      = w_wr & ~rst;
  assign resp_valid  = w_resp & ~rst;
  assign resp_err    = resp_valid & r_err;
  assign resp_rdata  = (resp_valid && !r_err && !r_wr) ? w_ext
                                                       : 32'h0000_0000;
  assign mem_addr    = (!rst && (r_state != S_IDLE))
                       ? {r_addr[15:2], 2'b00} : 16'h0000;
  assign mem_data_in = (!rst && (r_state == S_WR)) ? w_merge
                                                   : 32'h0000_0000;

endmodule
